// File: rtl/voq_cell_buffer_if.sv
// voq_cell_buffer_if
//   Handshake/data bundle between an ingress port, one VOQ cell buffer and the
//   mux control unit.
//   slave  : buffer side (accepts wr_*, rd_en_i; drives ready/full/rd_* outputs)
//   master : upstream/control side (drives wr_*, rd_en_i; observes the rest)
//   Signals:
//     wr_data_i/wr_valid_i/wr_ready_o : ingress word handshake
//     voq_full_o                      : >=1 complete cell stored
//     rd_en_i                         : pop request from the control unit
//     rd_data_o/rd_valid_o            : registered egress word
//     rd_sop_o/rd_eop_o               : first/last word of a cell
//     almost_full_o                   : only when VOQ_WATERMARK_EN is defined
interface voq_cell_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic                  voq_full_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  rd_sop_o;
  logic                  rd_eop_o;
`ifdef VOQ_WATERMARK_EN
  logic                  almost_full_o;
`endif

  modport slave (
    input  wr_data_i, wr_valid_i, rd_en_i,
    output wr_ready_o, voq_full_o, rd_data_o, rd_valid_o, rd_sop_o, rd_eop_o
`ifdef VOQ_WATERMARK_EN
    , output almost_full_o
`endif
  );

  modport master (
    output wr_data_i, wr_valid_i, rd_en_i,
    input  wr_ready_o, voq_full_o, rd_data_o, rd_valid_o, rd_sop_o, rd_eop_o
`ifdef VOQ_WATERMARK_EN
    , input almost_full_o
`endif
  );
endinterface

// File: rtl/voq_cell_buffer.sv
// voq_cell_buffer
//   Per-destination virtual output queue. Collects ingress words into fixed
//   size cells, flags voq_full_o while at least one complete cell is stored,
//   and drains one word per cycle while rd_en_i is high. Partial cells are
//   never popped.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, discards all contents
//     bus   : voq_cell_buffer_if.slave (write handshake, pop request,
//             registered egress word with sop/eop, voq_full_o)
//   Build option:
//     VOQ_WATERMARK_EN : adds bus.almost_full_o, high when free space is at
//                        most one cell.
module voq_cell_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CELL_WORDS  = 4,
  parameter int unsigned DEPTH_CELLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  voq_cell_buffer_if.slave   bus
);

  localparam int unsigned DEPTH = DEPTH_CELLS * CELL_WORDS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IW    = $clog2(CELL_WORDS);
  localparam int unsigned CCW   = $clog2(DEPTH_CELLS) + 1;

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   WC_ONE    = (AW+1)'(1);
  localparam logic [CCW-1:0] CC_ONE   = CCW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CELL_WORDS - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           word_cnt;
  logic [CCW-1:0]        cell_cnt;
  logic [IW-1:0]         wr_idx, rd_idx;

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, rd_sop_q, rd_eop_q;

  logic accept, pop, cell_done, eop_pop, rd_last;

  assign accept    = bus.wr_valid_i && bus.wr_ready_o;
  assign cell_done = accept && (wr_idx == IDX_LAST);
  assign rd_last   = (rd_idx == IDX_LAST);
  assign eop_pop   = pop && rd_last;

  // Pop decision. In DRAIN the current cell is guaranteed complete, so any
  // rd_en_i pops; IDLE only starts a cell when one is fully stored.
  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.rd_en_i && (cell_cnt != '0)) begin
          pop       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.rd_en_i) begin
          pop = 1'b1;
          if (rd_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      cell_cnt <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        wr_idx <= wr_idx + IDX_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_idx <= rd_idx + IDX_ONE;
      end
      unique case ({accept, pop})
        2'b10:   word_cnt <= word_cnt + WC_ONE;
        2'b01:   word_cnt <= word_cnt - WC_ONE;
        default: word_cnt <= word_cnt;
      endcase
      unique case ({cell_done, eop_pop})
        2'b10:   cell_cnt <= cell_cnt + CC_ONE;
        2'b01:   cell_cnt <= cell_cnt - CC_ONE;
        default: cell_cnt <= cell_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      rd_sop_q   <= pop && (rd_idx == '0);
      rd_eop_q   <= eop_pop;
      if (pop) rd_data_q <= mem[rd_ptr];
    end
  end

  // All status outputs decode registered counts only; no path from rd_en_i.
  assign bus.wr_ready_o = (word_cnt != DEPTH_W);
  assign bus.voq_full_o = (cell_cnt != '0);
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_sop_o   = rd_sop_q;
  assign bus.rd_eop_o   = rd_eop_q;

`ifdef VOQ_WATERMARK_EN
  localparam logic [AW:0] CELL_W = (AW+1)'(CELL_WORDS);
  assign bus.almost_full_o = ((DEPTH_W - word_cnt) <= CELL_W);
`endif

endmodule

// File: tb/tb_voq_cell_buffer.sv
// tb_voq_cell_buffer
//   Randomized and directed stimulus against a counting reference model of the
//   VOQ cell buffer. The driver updates the model at each rising edge and
//   queues expected egress words; a negedge monitor compares DUT outputs.
module tb_voq_cell_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DC    = 4;
  localparam int unsigned DEPTH = CW * DC;

  typedef struct {
    logic [DW-1:0] d;
    bit            sop;
    bit            eop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  voq_cell_buffer_if #(.DATA_WIDTH(DW)) bus ();

  voq_cell_buffer #(
    .DATA_WIDTH (DW),
    .CELL_WORDS (CW),
    .DEPTH_CELLS(DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: totals since reset plus a queue of stored words.
  int unsigned   n_wr, n_rd;
  logic [DW-1:0] mq[$];
  exp_t          exp_q[$];
  bit            popped_last;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  function automatic int unsigned m_words();
    return n_wr - n_rd;
  endfunction

  function automatic int unsigned m_cells();
    return (n_wr / CW) - (n_rd / CW);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_wr = 0;
    n_rd = 0;
    mq.delete();
    exp_q.delete();
    popped_last = 1'b0;
  endtask

  task automatic model_step();
    bit acc, mid, pp;
    acc = bus.wr_valid_i && (m_words() != DEPTH);
    mid = (n_rd % CW) != 0;
    pp  = bus.rd_en_i && (mid || (m_cells() != 0));
    popped_last = pp;
    if (pp) begin
      exp_t e;
      e.d   = mq.pop_front();
      e.sop = (n_rd % CW) == 0;
      e.eop = (n_rd % CW) == CW - 1;
      exp_q.push_back(e);
      n_rd++;
    end
    if (acc) begin
      mq.push_back(bus.wr_data_i);
      n_wr++;
    end
  endtask

  task automatic cycle(input bit wv, input bit re);
    @(negedge clk);
    #1;
    bus.wr_valid_i = wv;
    bus.wr_data_i  = $urandom;
    bus.rd_en_i    = re;
    @(posedge clk);
    if (rst_n) model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_data", bus.rd_data_o, '0);
    chk("rst_rd_valid", DW'(bus.rd_valid_o), '0);
    chk("rst_sop", DW'(bus.rd_sop_o), '0);
    chk("rst_eop", DW'(bus.rd_eop_o), '0);
    chk("rst_voq_full", DW'(bus.voq_full_o), '0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: registered status flags and the egress stream.
  always @(negedge clk) begin
    chk("wr_ready", DW'(bus.wr_ready_o), DW'(m_words() != DEPTH));
    chk("voq_full", DW'(bus.voq_full_o), DW'(m_cells() != 0));
`ifdef VOQ_WATERMARK_EN
    chk("almost_full", DW'(bus.almost_full_o), DW'((DEPTH - m_words()) <= CW));
`endif
    chk("rd_valid", DW'(bus.rd_valid_o), DW'(popped_last));
    if (popped_last && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (bus.rd_valid_o) begin
        chk("rd_data", bus.rd_data_o, e.d);
        chk("rd_sop", DW'(bus.rd_sop_o), DW'(e.sop));
        chk("rd_eop", DW'(bus.rd_eop_o), DW'(e.eop));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = '0;
    bus.rd_en_i    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Partial cell: never flagged, never popped.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    // Completing word, then a full drain.
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1);

    // Fill to capacity, attempt extra writes, then pop while full.
    repeat (DEPTH) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    // Mid-cell stall after two words.
    repeat (2) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (DEPTH + 4) cycle(1'b0, 1'b1);

    // Cell-completing write coincides with the eop pop of the prior cell.
    repeat (7) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1);

    // Reset mid-drain with two cells stored.
    repeat (8) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b1);
    do_reset();
    repeat (3) cycle(1'b0, 1'b1);

    // Watermark edge: 12 words then 11.
    repeat (12) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    do_reset();

    // Random segments with varying write/read pressure.
    for (int s = 0; s < 12; s++) begin
      int unsigned pw, pr;
      pw = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      for (int c = 0; c < 150; c++) begin
        cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
      end
    end
    repeat (DEPTH + 2) cycle(1'b0, 1'b1);

    cycle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("exp_q_empty", DW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
